mpc_sample_frontend: RTL and testbench

MPC_SAMPLE_FRONTEND -- requirements
Module: mpc_sample_frontend

---
 rtl/mpc_sample_frontend.sv | 117 +++++++++++
 tb/tb_mpc_sample_frontend.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mpc_sample_frontend.sv
// Double-flop synchroniser, 4-tap rounded moving average and decimated period latch per ADC channel,
// plus sticky over-current flag. Raw-to-w0 latency 3 cycles, strobe 1 cycle after terminal count; no backpressure.
module mpc_sample_frontend #(
   parameter int unsigned DECIM  = 16,
   parameter logic [7:0]  IL_MAX = 8'd230
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       en,
   input  logic [7:0] iL_raw,
   input  logic [7:0] vc_raw,
   input  logic [7:0] vg_raw,
   input  logic       fault_clr,
   output logic [7:0] iL,
   output logic [7:0] vc,
   output logic [7:0] vg,
   output logic       sample_valid,
   output logic       ocp_fault
);

   localparam int CW = $clog2(DECIM);

   logic [7:0]    raw [3];
   logic [7:0]    s1_q [3], s1_d [3];
   logic [7:0]    s2_q [3], s2_d [3];
   logic [7:0]    w_q [3][4], w_d [3][4];
   logic [9:0]    sum [3];
   logic [7:0]    filt [3];
   logic [7:0]    meas_q [3], meas_d [3];
   logic [2:0]    fill_q, fill_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sample_valid_q, sample_valid_d;
   logic          ocp_fault_q, ocp_fault_d;
   logic          filled, term, load;

   assign raw[0] = iL_raw;
   assign raw[1] = vc_raw;
   assign raw[2] = vg_raw;

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         s1_d[c]   = raw[c];
         s2_d[c]   = s1_q[c];
         w_d[c][0] = s2_q[c];
         for (int k = 1; k < 4; k++) begin
            w_d[c][k] = w_q[c][k-1];
         end
         sum[c]  = {2'b00, w_q[c][0]} + {2'b00, w_q[c][1]}
                 + {2'b00, w_q[c][2]} + {2'b00, w_q[c][3]};
         // Round-half-up divide by 4; 1020+2 still fits in 10 bits.
         filt[c] = 8'((sum[c] + 10'd2) >> 2);
      end

      filled = (fill_q == 3'd4);
      term   = en && (cnt_q == CW'(DECIM - 1));
      load   = term && filled;

      fill_d = filled ? fill_q : fill_q + 3'd1;

      cnt_d = cnt_q;
      if (term) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end

      for (int c = 0; c < 3; c++) begin
         meas_d[c] = load ? filt[c] : meas_q[c];
      end
      sample_valid_d = load;

      // Setting on a fresh over-limit load outranks a simultaneous clear.
      ocp_fault_d = ocp_fault_q;
      if (load && (filt[0] > IL_MAX)) begin
         ocp_fault_d = 1'b1;
      end else if (fault_clr) begin
         ocp_fault_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int c = 0; c < 3; c++) begin
            s1_q[c]   <= '0;
            s2_q[c]   <= '0;
            meas_q[c] <= '0;
            for (int k = 0; k < 4; k++) begin
               w_q[c][k] <= '0;
            end
         end
         fill_q         <= '0;
         cnt_q          <= '0;
         sample_valid_q <= 1'b0;
         ocp_fault_q    <= 1'b0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            s1_q[c]   <= s1_d[c];
            s2_q[c]   <= s2_d[c];
            meas_q[c] <= meas_d[c];
            for (int k = 0; k < 4; k++) begin
               w_q[c][k] <= w_d[c][k];
            end
         end
         fill_q         <= fill_d;
         cnt_q          <= cnt_d;
         sample_valid_q <= sample_valid_d;
         ocp_fault_q    <= ocp_fault_d;
      end
   end

   assign iL           = meas_q[0];
   assign vc           = meas_q[1];
   assign vg           = meas_q[2];
   assign sample_valid = sample_valid_q;
   assign ocp_fault    = ocp_fault_q;

endmodule

// File: tb/tb_mpc_sample_frontend.sv
// Bench for mpc_sample_frontend: DECIM=16 and DECIM=4 instances share stimulus; a raw-history
// reference model queues expected strobes, and a negedge monitor compares them and held outputs.
module tb_mpc_sample_frontend;

   localparam int IL_LIM = 230;

   logic       clk = 1'b0;
   logic       rst, en, clr;
   logic [7:0] il_raw, vc_raw, vg_raw;
   logic [7:0] il16, vc16, vg16, il4, vc4, vg4;
   logic       sv16, sv4, ocp16, ocp4;

   always #5 clk = ~clk;

   mpc_sample_frontend #(.DECIM(16), .IL_MAX(8'd230)) dut16 (
      .wb_clk_i(clk), .wb_rst_i(rst), .en(en),
      .iL_raw(il_raw), .vc_raw(vc_raw), .vg_raw(vg_raw), .fault_clr(clr),
      .iL(il16), .vc(vc16), .vg(vg16), .sample_valid(sv16), .ocp_fault(ocp16)
   );

   mpc_sample_frontend #(.DECIM(4), .IL_MAX(8'd230)) dut4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .en(en),
      .iL_raw(il_raw), .vc_raw(vc_raw), .vg_raw(vg_raw), .fault_clr(clr),
      .iL(il4), .vc(vc4), .vg(vg4), .sample_valid(sv4), .ocp_fault(ocp4)
   );

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  il, vc, vg;
      logic        ocp;
   } exp_t;

   exp_t q0[$], q1[$];
   int   checks = 0, errors = 0;
   int   cyc = 0;
   bit   mon_on = 0;

   // Reference model: raw history per edge (0 on reset edges), counters as plain integers.
   int decim [2] = '{16, 4};
   int h_il [6], h_vc [6], h_vg [6];
   int fillc = 0;
   int mcnt [2], mocp [2], held_il [2], held_vc [2], held_vg [2];

   initial begin
      for (int k = 0; k < 6; k++) begin
         h_il[k] = 0; h_vc[k] = 0; h_vg[k] = 0;
      end
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = 0; mocp[i] = 0; held_il[i] = 0; held_vc[i] = 0; held_vg[i] = 0;
      end
   end

   always @(posedge clk) begin
      int   f_il, f_vc, f_vg;
      bit   term;
      exp_t e;
      cyc++;
      if (rst) begin
         fillc = 0;
         for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mocp[i] = 0; held_il[i] = 0; held_vc[i] = 0; held_vg[i] = 0;
         end
      end else begin
         // Window before this edge holds the raw values sampled 3..6 edges ago.
         f_il = (h_il[2] + h_il[3] + h_il[4] + h_il[5] + 2) / 4;
         f_vc = (h_vc[2] + h_vc[3] + h_vc[4] + h_vc[5] + 2) / 4;
         f_vg = (h_vg[2] + h_vg[3] + h_vg[4] + h_vg[5] + 2) / 4;
         for (int i = 0; i < 2; i++) begin
            term = en && (mcnt[i] == decim[i] - 1);
            if (term) mcnt[i] = 0;
            else if (en) mcnt[i] = mcnt[i] + 1;
            if (term && fillc >= 4) begin
               held_il[i] = f_il; held_vc[i] = f_vc; held_vg[i] = f_vg;
               if (f_il > IL_LIM) mocp[i] = 1;
               else if (clr) mocp[i] = 0;
               e.cyc = cyc; e.il = 8'(f_il); e.vc = 8'(f_vc); e.vg = 8'(f_vg); e.ocp = mocp[i][0];
               if (i == 0) q0.push_back(e);
               else q1.push_back(e);
            end else if (clr) begin
               mocp[i] = 0;
            end
         end
         if (fillc < 4) fillc++;
      end
      for (int k = 5; k > 0; k--) begin
         h_il[k] = h_il[k-1]; h_vc[k] = h_vc[k-1]; h_vg[k] = h_vg[k-1];
      end
      h_il[0] = rst ? 0 : int'(il_raw);
      h_vc[0] = rst ? 0 : int'(vc_raw);
      h_vg[0] = rst ? 0 : int'(vg_raw);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_inst(input int i, input string tag, input logic sv,
                             input logic [7:0] ail, input logic [7:0] avc,
                             input logic [7:0] avg, input logic aocp);
      exp_t e;
      bit   have;
      have = 0;
      if (i == 0 && q0.size() > 0 && int'(q0[0].cyc) <= cyc) begin e = q0.pop_front(); have = 1; end
      if (i == 1 && q1.size() > 0 && int'(q1[0].cyc) <= cyc) begin e = q1.pop_front(); have = 1; end
      if (have) begin
         chk({tag, "_strobe_present"}, int'(sv), 1);
         chk({tag, "_strobe_il"}, int'(ail), int'(e.il));
         chk({tag, "_strobe_vc"}, int'(avc), int'(e.vc));
         chk({tag, "_strobe_vg"}, int'(avg), int'(e.vg));
         chk({tag, "_strobe_ocp"}, int'(aocp), int'(e.ocp));
      end else begin
         chk({tag, "_no_strobe"}, int'(sv), 0);
      end
      chk({tag, "_held_il"}, int'(ail), held_il[i]);
      chk({tag, "_held_vc"}, int'(avc), held_vc[i]);
      chk({tag, "_held_vg"}, int'(avg), held_vg[i]);
      chk({tag, "_ocp"}, int'(aocp), mocp[i]);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         check_inst(0, "d16", sv16, il16, vc16, vg16, ocp16);
         check_inst(1, "d4", sv4, il4, vc4, vg4, ocp4);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cnt(input int c);
      for (int k = 0; k < 64; k++) begin
         if (mcnt[0] == c) return;
         @(negedge clk);
      end
      chk("wait_cnt_timeout", mcnt[0], c);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0;
      il_raw = 8'd0; vc_raw = 8'd0; vg_raw = 8'd0;
      step(3);
      mon_on = 1;

      // Constant inputs after reset: first strobes, DECIM=4 skips its unfilled terminal event.
      il_raw = 8'd100; vc_raw = 8'd50; vg_raw = 8'd30; en = 1'b1; rst = 1'b0;
      step(40);

      // Window 10,11,11,11 at a DECIM=16 terminal event -> rounded mean 11.
      wait_cnt(9);
      for (int k = 0; k < 8; k++) begin
         if (mcnt[0] == 9) il_raw = 8'd10;
         else if (mcnt[0] >= 10 && mcnt[0] <= 12) il_raw = 8'd11;
         else il_raw = 8'd200;
         step(1);
      end
      step(10);

      // Randomized traffic with sporadic enable drops and clears.
      for (int k = 0; k < 300; k++) begin
         il_raw = 8'($urandom); vc_raw = 8'($urandom); vg_raw = 8'($urandom);
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 19) == 0);
         step(1);
      end
      clr = 1'b0; en = 1'b1;

      // Enable dropped for 5 cycles mid-period stretches that period only.
      il_raw = 8'd80; vc_raw = 8'd60; vg_raw = 8'd40;
      step(20);
      wait_cnt(7);
      en = 1'b0;
      step(5);
      en = 1'b1;
      step(40);

      // Over-current: set, stays after current drops, clears, then set beats clear.
      il_raw = 8'd240;
      step(40);
      il_raw = 8'd100;
      step(40);
      clr = 1'b1; step(1); clr = 1'b0;
      step(5);
      il_raw = 8'd240;
      step(40);
      wait_cnt(15);
      clr = 1'b1; step(1); clr = 1'b0;
      step(10);
      il_raw = 8'd100;
      step(10);
      clr = 1'b1; step(1); clr = 1'b0;
      step(5);

      // Reset mid-period discards the partial count.
      wait_cnt(9);
      rst = 1'b1; step(1); rst = 1'b0;
      step(40);

      step(5);
      chk("q16_drained", q0.size(), 0);
      chk("q4_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
